regfile_ctx_seq: RTL and testbench

Context save/restore sequencer for the CPU register file. On command it takes ownership of the register file's write port and read port A. It streams a contiguous index range out over a valid/ready save channel, or writes a range back from a valid/ready restore channel. When idle it is a transparent passthrough for the core's write port and read port A.

---
 rtl/regfile_ctx_seq_pkg.sv | 14 +
 rtl/regfile_ctx_seq_if.sv | 55 +++++
 rtl/regfile_ctx_seq_counter.sv | 35 +++
 rtl/regfile_ctx_seq.sv | 90 +++++++++
 tb/tb_regfile_ctx_seq.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctx_seq_pkg.sv
// Shared types and constants for the register-file context sequencer.
package regfile_ctx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } ctx_state_t;

    localparam logic CTX_CMD_SAVE    = 1'b1;
    localparam logic CTX_CMD_RESTORE = 1'b0;

endpackage

// File: rtl/regfile_ctx_seq_if.sv
// Bundle of command, core, register-file and stream signals around the sequencer.
// slave = sequencer view, master = environment view.
interface regfile_ctx_seq_if #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
);
    localparam int COUNT_BITS = $clog2(COUNT);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_save;
    logic [COUNT_BITS-1:0] cmd_first;
    logic [COUNT_BITS-1:0] cmd_last;
    logic                  busy;
    logic                  done;

    logic [WORD_SIZE-1:0]  core_data_in;
    logic [COUNT_BITS-1:0] core_idx_write;
    logic                  core_en_write;
    logic [COUNT_BITS-1:0] core_idx_out_a;

    logic [WORD_SIZE-1:0]  rf_data_in;
    logic [COUNT_BITS-1:0] rf_idx_write;
    logic                  rf_en_write;
    logic [COUNT_BITS-1:0] rf_idx_out_a;
    logic [WORD_SIZE-1:0]  rf_data_out_a;

    logic                  sv_valid;
    logic                  sv_ready;
    logic [WORD_SIZE-1:0]  sv_data;
    logic [COUNT_BITS-1:0] sv_idx;

    logic                  rs_valid;
    logic                  rs_ready;
    logic [WORD_SIZE-1:0]  rs_data;

    modport slave (
        input  cmd_valid, cmd_save, cmd_first, cmd_last,
        input  core_data_in, core_idx_write, core_en_write, core_idx_out_a,
        input  rf_data_out_a, sv_ready, rs_valid, rs_data,
        output cmd_ready, busy, done,
        output rf_data_in, rf_idx_write, rf_en_write, rf_idx_out_a,
        output sv_valid, sv_data, sv_idx, rs_ready
    );

    modport master (
        output cmd_valid, cmd_save, cmd_first, cmd_last,
        output core_data_in, core_idx_write, core_en_write, core_idx_out_a,
        output rf_data_out_a, sv_ready, rs_valid, rs_data,
        input  cmd_ready, busy, done,
        input  rf_data_in, rf_idx_write, rf_en_write, rf_idx_out_a,
        input  sv_valid, sv_data, sv_idx, rs_ready
    );

endinterface

// File: rtl/regfile_ctx_seq_counter.sv
// Index/remaining counter for a contiguous, wrapping register range.
// remaining counts words left after the current one, so last_o marks the final word.
module ctx_range_counter #(
    parameter int COUNT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [COUNT_BITS-1:0] first_i,
    input  logic [COUNT_BITS-1:0] last_i,
    input  logic                  step_i,
    output logic [COUNT_BITS-1:0] idx_o,
    output logic                  last_o
);
    logic [COUNT_BITS-1:0] idx_q;
    logic [COUNT_BITS-1:0] rem_q;

    // Load on command accept, advance one word per transfer; wraps modulo COUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            idx_q <= first_i;
            rem_q <= last_i - first_i;
        end else if (step_i) begin
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer: owns the register-file write port and read
// port A while streaming a range out (save) or in (restore); passthrough when idle.
module regfile_ctx_seq
    import regfile_ctx_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
) (
    input  logic             clk,
    input  logic             rst,
    regfile_ctx_seq_if.slave bus
);
    localparam int COUNT_BITS = $clog2(COUNT);

    ctx_state_t            state_q, state_d;
    logic                  load, step, last;
    logic [COUNT_BITS-1:0] idx;
    logic [WORD_SIZE-1:0]  save_word;

    assign save_word = bus.rf_data_out_a;

    ctx_range_counter #(.COUNT_BITS(COUNT_BITS)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .first_i (bus.cmd_first),
        .last_i  (bus.cmd_last),
        .step_i  (step),
        .idx_o   (idx),
        .last_o  (last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

    // Next state and port mux: core passthrough in IDLE, sequencer-driven otherwise.
    always_comb begin
        state_d          = state_q;
        load             = 1'b0;
        step             = 1'b0;
        bus.cmd_ready    = 1'b0;
        bus.sv_valid     = 1'b0;
        bus.sv_data      = '0;
        bus.sv_idx       = '0;
        bus.rs_ready     = 1'b0;
        bus.rf_data_in   = bus.core_data_in;
        bus.rf_idx_write = bus.core_idx_write;
        bus.rf_en_write  = 1'b0;
        bus.rf_idx_out_a = bus.core_idx_out_a;
        case (state_q)
            IDLE: begin
                bus.cmd_ready   = 1'b1;
                bus.rf_en_write = bus.core_en_write;
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    state_d = (bus.cmd_save == CTX_CMD_SAVE) ? SAVE : RESTORE;
                end
            end
            SAVE: begin
                bus.rf_idx_out_a = idx;
                bus.sv_valid     = 1'b1;
                bus.sv_data      = save_word;
                bus.sv_idx       = idx;
                if (bus.sv_ready) begin
                    if (last) state_d = DONE;
                    else      step    = 1'b1;
                end
            end
            RESTORE: begin
                bus.rs_ready     = 1'b1;
                bus.rf_idx_write = idx;
                bus.rf_data_in   = bus.rs_data;
                bus.rf_en_write  = bus.rs_valid;
                if (bus.rs_valid) begin
                    if (last) state_d = DONE;
                    else      step    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Bench for regfile_ctx_seq: register-file environment, queue-based reference
// model compared every cycle, and directed + randomized operations.
module tb_regfile_ctx_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_ctx_seq_if #(.WORD_SIZE(16), .COUNT(32)) bus ();

    regfile_ctx_seq #(.WORD_SIZE(16), .COUNT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Register file environment, reset together with the sequencer.
    logic [15:0] rf [32];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.rf_en_write) begin
            rf[bus.rf_idx_write] <= bus.rf_data_in;
        end
    end
    assign bus.rf_data_out_a = rf[bus.rf_idx_out_a];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pv(input int i);
        return 16'((i * 257) ^ 16'h5A5A);
    endfunction

    // Reference model: a queue of indices still to transfer plus a done flag.
    logic [15:0] exp_mem [32];
    int          q [$];
    bit          m_busy = 0, m_save = 0, m_done = 0;
    int          log_idx [$];
    int          log_dat [$];
    int          done_cnt = 0;

    initial begin
        bit act, sav, rsv;
        int n;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_done = 0; q.delete();
                for (int i = 0; i < 32; i++) exp_mem[i] = '0;
            end
            act = m_busy && !m_done;
            sav = act && m_save;
            rsv = act && !m_save;
            chk("busy",      bus.busy,      m_busy);
            chk("done",      bus.done,      m_done);
            chk("cmd_ready", bus.cmd_ready, !m_busy);
            chk("sv_valid",  bus.sv_valid,  sav);
            chk("rs_ready",  bus.rs_ready,  rsv);
            chk("sv_idx",    bus.sv_idx,    sav ? q[0] : 0);
            chk("sv_data",   bus.sv_data,   sav ? exp_mem[q[0]] : 16'h0);
            chk("rf_en_write", bus.rf_en_write,
                !m_busy ? bus.core_en_write : (rsv ? bus.rs_valid : 1'b0));
            if (!m_busy) begin
                chk("pass_idx_write", bus.rf_idx_write, bus.core_idx_write);
                chk("pass_data_in",   bus.rf_data_in,   bus.core_data_in);
                chk("pass_idx_out_a", bus.rf_idx_out_a, bus.core_idx_out_a);
                chk("pass_read_a",    bus.rf_data_out_a, exp_mem[bus.core_idx_out_a]);
            end
            if (rsv) begin
                chk("rs_idx_write", bus.rf_idx_write, q[0]);
                chk("rs_data_in",   bus.rf_data_in,   bus.rs_data);
                chk("rs_idx_out_a", bus.rf_idx_out_a, bus.core_idx_out_a);
            end
            if (sav) chk("sv_idx_out_a", bus.rf_idx_out_a, q[0]);
            if (bus.sv_valid && bus.sv_ready) begin
                log_idx.push_back(int'(bus.sv_idx));
                log_dat.push_back(int'(bus.sv_data));
            end
            if (bus.done) done_cnt++;
            // Advance the model by the edge that follows, using the inputs held now.
            if (!rst) begin
                if (!m_busy) begin
                    if (bus.core_en_write) exp_mem[bus.core_idx_write] = bus.core_data_in;
                    if (bus.cmd_valid) begin
                        n = ((int'(bus.cmd_last) - int'(bus.cmd_first)) & 31) + 1;
                        for (int k = 0; k < n; k++) q.push_back((int'(bus.cmd_first) + k) % 32);
                        m_busy = 1; m_save = bus.cmd_save; m_done = 0;
                    end
                end else if (m_done) begin
                    m_busy = 0; m_done = 0;
                end else if (m_save) begin
                    if (bus.sv_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) m_done = 1;
                    end
                end else if (bus.rs_valid) begin
                    exp_mem[q[0]] = bus.rs_data;
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit sv, input int first, input int last);
        bus.cmd_save  = sv;
        bus.cmd_first = 5'(first);
        bus.cmd_last  = 5'(last);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_op(input bit rnd, input int budget, output int cycles);
        cycles = 1;
        while (bus.busy && cycles < budget) begin
            if (rnd) begin
                bus.sv_ready       = 1'($urandom);
                bus.rs_valid       = 1'($urandom);
                bus.rs_data        = 16'($urandom);
                bus.core_en_write  = 1'($urandom);
                bus.core_idx_write = 5'($urandom);
                bus.core_data_in   = 16'($urandom);
                bus.core_idx_out_a = 5'($urandom);
            end
            step();
            cycles++;
        end
        if (bus.busy) chk("op_timeout", 1, 0);
        bus.sv_ready = 1'b0;
        bus.rs_valid = 1'b0;
        bus.core_en_write = 1'b0;
    endtask

    initial begin
        int cyc, k, i, j, d0;
        bit v;
        bit          pat [8]  = '{0, 1, 1, 0, 0, 1, 0, 1};
        logic [15:0] vals [4] = '{16'hA, 16'hB, 16'hC, 16'hD};
        int          rb_idx [4] = '{30, 31, 0, 1};

        bus.cmd_valid = 0; bus.cmd_save = 0; bus.cmd_first = 0; bus.cmd_last = 0;
        bus.core_data_in = 0; bus.core_idx_write = 0; bus.core_en_write = 0;
        bus.core_idx_out_a = 0; bus.sv_ready = 0; bus.rs_valid = 0; bus.rs_data = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sv_valid", bus.sv_valid, 0);
        chk("rst_rs_ready", bus.rs_ready, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        step();
        rst = 1'b0;
        step();

        // Preload the whole file through a full-range restore
        issue_cmd(0, 0, 31);
        k = 0;
        while (bus.busy && k < 40) begin
            bus.rs_valid = 1'b1;
            bus.rs_data  = pv(k);
            step();
            k++;
        end
        bus.rs_valid = 1'b0;
        chk("preload_words", k, 33);

        // 1: idle passthrough
        bus.core_en_write = 1; bus.core_idx_write = 5; bus.core_data_in = 16'h1234;
        bus.core_idx_out_a = 5;
        @(negedge clk);
        chk("t1_en", bus.rf_en_write, 1);
        chk("t1_idx", bus.rf_idx_write, 5);
        chk("t1_data", bus.rf_data_in, 16'h1234);
        step();
        bus.core_en_write = 0;
        @(negedge clk);
        chk("t1_read", bus.rf_data_out_a, 16'h1234);
        step();

        // 2: save 3..6, always ready
        log_idx.delete(); log_dat.delete(); d0 = done_cnt;
        bus.sv_ready = 1;
        issue_cmd(1, 3, 6);
        run_op(0, 50, cyc);
        chk("t2_cycles", cyc, 6);
        chk("t2_count", log_idx.size(), 4);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_i0", log_idx[0], 3); chk("t2_d0", log_dat[0], pv(3));
        chk("t2_i1", log_idx[1], 4); chk("t2_d1", log_dat[1], pv(4));
        chk("t2_i2", log_idx[2], 5); chk("t2_d2", log_dat[2], 16'h1234);
        chk("t2_i3", log_idx[3], 6); chk("t2_d3", log_dat[3], pv(6));

        // 3: save 2..3 with ready toggling
        log_idx.delete(); log_dat.delete(); d0 = done_cnt;
        bus.sv_ready = 0;
        issue_cmd(1, 2, 3);
        i = 0;
        while (bus.busy && i < 20) begin
            bus.sv_ready = (i % 2) == 1;
            @(negedge clk);
            if (i < 2) begin
                chk("t3_hold_idx", bus.sv_idx, 2);
                chk("t3_hold_data", bus.sv_data, pv(2));
            end
            step();
            i++;
        end
        bus.sv_ready = 0;
        chk("t3_count", log_idx.size(), 2);
        chk("t3_i0", log_idx[0], 2);
        chk("t3_i1", log_idx[1], 3);
        chk("t3_done", done_cnt - d0, 1);

        // 4: restore 30..1 wrapping, gapped valid, core writes while busy
        issue_cmd(0, 30, 1);
        bus.core_en_write = 1; bus.core_idx_write = 9; bus.core_data_in = 16'hDEAD;
        i = 0; j = 0;
        while (bus.busy && i < 20) begin
            v = (i < 8) ? pat[i] : 1'b1;
            bus.rs_valid = v;
            if (v) begin
                bus.rs_data = vals[j];
                j = (j < 3) ? j + 1 : 3;
            end
            step();
            i++;
        end
        bus.rs_valid = 0; bus.core_en_write = 0;
        chk("t4_finished", bus.busy, 0);
        for (int r = 0; r < 4; r++) begin
            bus.core_idx_out_a = 5'(rb_idx[r]);
            @(negedge clk);
            chk("t4_readback", bus.rf_data_out_a, vals[r]);
            step();
        end
        bus.core_idx_out_a = 9;
        @(negedge clk);
        chk("t4_core_dropped", bus.rf_data_out_a, pv(9));
        step();

        // 5: command in the same cycle as a core write
        log_idx.delete(); log_dat.delete();
        bus.core_en_write = 1; bus.core_idx_write = 7; bus.core_data_in = 16'h55;
        bus.sv_ready = 1;
        issue_cmd(1, 7, 7);
        bus.core_en_write = 0;
        run_op(0, 50, cyc);
        chk("t5_count", log_idx.size(), 1);
        chk("t5_idx", log_idx[0], 7);
        chk("t5_data", log_dat[0], 16'h55);
        chk("t5_cycles", cyc, 3);

        // Randomized operations
        for (int op = 0; op < 40; op++) begin
            k = $urandom_range(1, 3);
            for (int c = 0; c < k; c++) begin
                bus.core_en_write  = 1'($urandom);
                bus.core_idx_write = 5'($urandom);
                bus.core_data_in   = 16'($urandom);
                bus.core_idx_out_a = 5'($urandom);
                step();
            end
            issue_cmd(1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31));
            run_op(1, 400, cyc);
        end

        // 6: reset in the middle of a save
        log_idx.delete(); log_dat.delete(); d0 = done_cnt;
        bus.sv_ready = 1;
        issue_cmd(1, 0, 7);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_sv_valid", bus.sv_valid, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_words", log_idx.size(), 2);
        chk("t6_i0", log_idx[0], 0);
        chk("t6_i1", log_idx[1], 1);
        step();
        rst = 1'b0;
        bus.sv_ready = 0;
        @(negedge clk);
        chk("t6_cmd_ready", bus.cmd_ready, 1);
        chk("t6_no_done", done_cnt - d0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
